// File: rtl/pc_sequencer.sv
// Next-PC controller: drives jump_en/target for a relative-jump PC.
// Owns the branch-offset LUT, the return-address stack and run state.
module pc_sequencer #(
    parameter int D     = 12,
    parameter int L     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [D-1:0]           prog_ctr,
    input  logic                   halt,
    input  logic                   branch,
    input  logic                   cond,
    input  logic                   call,
    input  logic                   ret,
    input  logic [L-1:0]           lut_idx,
    input  logic                   cfg_we,
    input  logic [L-1:0]           cfg_addr,
    input  logic [D-1:0]           cfg_data,
    output logic                   jump_en,
    output logic [D-1:0]           target,
    output logic                   done,
    output logic                   fault,
    output logic [$clog2(DEPTH):0] sp
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam int NL  = 2 ** L;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [D-1:0]   PC_ONE  = D'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED,
        FAULT
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [D-1:0]   lut   [NL];
    logic [D-1:0]   stack [DEPTH];
    logic           push;
    logic           pop;
    logic [SPW-1:0] sp_dec;
    logic [D-1:0]   tos;

    assign sp_dec = sp - SP_ONE;
    assign tos    = stack[sp_dec[AW-1:0]];
    assign done   = (state == HALTED);
    assign fault  = (state == FAULT);

    // State register; reset drops straight back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and PC control; every non-RUN state holds the PC
    always_comb begin
        state_n = state;
        jump_en = 1'b1;
        target  = '0;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (call && ret) begin
                    state_n = FAULT;
                end else if (halt) begin
                    state_n = HALTED;
                end else if (ret) begin
                    if (sp == '0) begin
                        state_n = FAULT;
                    end else begin
                        target = tos - prog_ctr;
                        pop    = 1'b1;
                    end
                end else if (call) begin
                    if (sp == SP_FULL) begin
                        state_n = FAULT;
                    end else begin
                        target = lut[lut_idx];
                        push   = 1'b1;
                    end
                end else if (branch && cond) begin
                    target = lut[lut_idx];
                end else begin
                    jump_en = 1'b0;
                end
            end
            HALTED: begin
                if (start) state_n = RUN;
            end
            FAULT: begin
                state_n = FAULT;
            end
        endcase
    end

    // Return stack: push return address on call, drop top on return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else if (push) begin
            stack[sp[AW-1:0]] <= prog_ctr + PC_ONE;
            sp                <= sp + SP_ONE;
        end else if (pop) begin
            sp <= sp_dec;
        end
    end

    // Offset LUT; a same-cycle read sees the pre-write value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) lut[i] <= '0;
        end else if (cfg_we) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

endmodule
